// File: rtl/vec_int_ctrl.sv
// vec_int_ctrl: collects device irq edges and issues one prioritised vectored request to the core.
// Latency: irq edge in cycle N -> pending at N+1 -> interrupt at N+2; int_ack/eoi act on the next edge.
// Backpressure: one request outstanding; interrupt held until int_ack, next request blocked until eoi.
// Build option: define VEC_INT_CTRL_TIMEOUT_EN to withdraw a request left unacknowledged for ACK_TIMEOUT cycles.
module vec_int_ctrl #(
    parameter int          NSRC        = 4,
    parameter logic [31:0] VEC_BASE    = 32'h0000_0180,
    parameter int          VEC_SHIFT   = 4,
    parameter int          ACK_TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] irq_in,
    input  logic            mask_we,
    input  logic [NSRC-1:0] mask_wd,
    output logic [NSRC-1:0] mask,
    output logic            interrupt,
    input  logic            int_ack,
    output logic [31:0]     vector,
    output logic [2:0]      int_id,
    input  logic            eoi,
    output logic            busy,
    output logic [NSRC-1:0] pending,
    output logic            timeout_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t          state;
    logic [NSRC-1:0] irq_d;
    logic            edge_en;
    logic [NSRC-1:0] irq_edge;
    logic [NSRC-1:0] eligible;
    logic [NSRC-1:0] ack_clr;
    logic            ack_take;
    logic            any_elig;
    logic [2:0]      winner;
    logic [31:0]     win_vector;

`ifdef VEC_INT_CTRL_TIMEOUT_EN
    localparam int             CW       = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0]  ACK_LAST = CW'(ACK_TIMEOUT - 1);

    logic [CW-1:0] ack_cnt;
    logic          ack_expired;

    // The request has been up for ACK_TIMEOUT cycles once this REQ cycle ends.
    assign ack_expired = (ack_cnt == ACK_LAST);
`else
    // ACK_TIMEOUT has no effect in this build; the flag is permanently clear.
    logic unused_ack_timeout;
    assign unused_ack_timeout = ^ACK_TIMEOUT;
    assign timeout_err        = 1'b0;
`endif

    // edge_en masks the first cycle after reset so lines already high at release are not seen as edges.
    assign irq_edge = irq_in & ~irq_d & {NSRC{edge_en}};
    assign eligible = pending & ~mask;
    assign any_elig = |eligible;
    assign ack_take = (state == REQ) && int_ack;
    assign win_vector = VEC_BASE + ({29'd0, winner} << VEC_SHIFT);

    // Lowest eligible index wins; scanning downward leaves the lowest one in winner.
    always_comb begin
        winner = 3'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = 3'(i);
            end
        end
    end

    // One-hot clear of the acknowledged source.
    always_comb begin
        ack_clr = '0;
        for (int i = 0; i < NSRC; i++) begin
            ack_clr[i] = ack_take && (int_id == 3'(i));
        end
    end

    // Edge-detect history and the post-reset arming flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_d   <= '0;
            edge_en <= 1'b0;
        end else begin
            irq_d   <= irq_in;
            edge_en <= 1'b1;
        end
    end

    // Pending latch: a new edge overrides a same-cycle acknowledge clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~ack_clr) | irq_edge;
        end
    end

    // Software-written mask register (1 = source disabled).
    always_ff @(posedge clk) begin
        if (reset) begin
            mask <= '0;
        end else if (mask_we) begin
            mask <= mask_wd;
        end
    end

    // Request handshake FSM; interrupt, busy, vector and int_id are registered alongside state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            interrupt <= 1'b0;
            busy      <= 1'b0;
            vector    <= '0;
            int_id    <= '0;
`ifdef VEC_INT_CTRL_TIMEOUT_EN
            ack_cnt     <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_elig) begin
                        state     <= REQ;
                        interrupt <= 1'b1;
                        busy      <= 1'b1;
                        int_id    <= winner;
                        vector    <= win_vector;
`ifdef VEC_INT_CTRL_TIMEOUT_EN
                        ack_cnt   <= '0;
`endif
                    end
                end
                REQ: begin
                    // int_ack takes precedence over an expiring timeout in the same cycle.
                    if (int_ack) begin
                        state     <= SERVICE;
                        interrupt <= 1'b0;
                    end
`ifdef VEC_INT_CTRL_TIMEOUT_EN
                    else if (ack_expired) begin
                        // Pending bit is left set so the source is re-arbitrated from IDLE.
                        state       <= IDLE;
                        interrupt   <= 1'b0;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        ack_cnt <= ack_cnt + CW'(1);
                    end
`endif
                end
                SERVICE: begin
                    if (eoi) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    interrupt <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
